// File: rtl/vmem_wr_buffer_pkg.sv
// Shared definitions for the VMEM posted-write buffer.
// Holds the default geometry, the reduced colour type and a helper that
// sizes index registers for a given number of cores.
package vmem_wr_buffer_pkg;

  localparam int NCORES_DEF     = 2;
  localparam int VMEM_ADDRW_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  // Colour as stored in video memory: {R, G, B}, one bit each.
  typedef logic [2:0] rgb3_t;

  // Width of a register that indexes n items; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vmem_wr_fifo.sv
// Per-core synchronous FIFO for posted VMEM writes.
// Storage is a plain register array (no reset on the payload); only the
// pointers and occupancy count are reset. full/empty are decoded from the
// registered count, so a full FIFO refuses a push even while it pops.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push, din   write request and entry
//   pop         read request; dout shows the head entry
//   full, empty occupancy flags
module vmem_wr_fifo #(
  parameter int DATA_W     = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers are exactly log2(depth) bits wide and wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vmem_wr_buffer.sv
// Posted-write buffer in front of the single write port of video memory.
// Each core owns a small FIFO, so a store completes as soon as it is queued.
// Queued stores drain one per cycle, chosen round-robin across cores, and
// the RGB565 pixel is reduced to the 3-bit colour the RAM stores.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   we_packed_i      per-core store request, held while stalled
//   addr_packed_i    per-core pixel address, core i at [i*VMEM_ADDRW +: VMEM_ADDRW]
//   wdata_packed_i   per-core store data, only [15:0] (RGB565) is used
//   stall_packed_o   per-core stall (combinational): request while FIFO full
//   mem_we_o         registered RAM write enable
//   mem_waddr_o      registered RAM write address
//   mem_wdata_o      registered RAM write data {R,G,B}
//   busy_o           any FIFO non-empty or a RAM write in flight
module vmem_wr_buffer
  import vmem_wr_buffer_pkg::*;
#(
  parameter int NCORES     = NCORES_DEF,
  parameter int VMEM_ADDRW = VMEM_ADDRW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NCORES-1:0]        we_packed_i,
  input  logic [VMEM_ADDRW*NCORES-1:0] addr_packed_i,
  input  logic [32*NCORES-1:0]     wdata_packed_i,
  output logic [NCORES-1:0]        stall_packed_o,
  output logic                     mem_we_o,
  output logic [VMEM_ADDRW-1:0]    mem_waddr_o,
  output logic [2:0]               mem_wdata_o,
  output logic                     busy_o
);

  localparam int ENT_W = VMEM_ADDRW + 3;
  localparam int PTR_W = idx_width(NCORES);

  // Keep the most significant bit of each of R, G and B.
  function automatic rgb3_t rgb565_to_rgb3(input logic [15:0] d);
    return {d[15], d[10], d[4]};
  endfunction

  logic [NCORES-1:0] full;
  logic [NCORES-1:0] empty;
  logic [NCORES-1:0] push;
  logic [NCORES-1:0] pop;
  logic [ENT_W-1:0]  ent_in  [NCORES];
  logic [ENT_W-1:0]  ent_out [NCORES];

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  rr_next;
  logic              gnt_vld;
  logic [ENT_W-1:0]  sel_ent;

  logic                  vld_p1;
  logic [VMEM_ADDRW-1:0] waddr_p1;
  rgb3_t                 wdata_p1;

  // Only RGB565 bits of the store word are meaningful.
  logic unused_wdata;
  assign unused_wdata = ^wdata_packed_i;

  // ---- stage p0: per-core queueing ----
  for (genvar i = 0; i < NCORES; i++) begin : g_core
    assign ent_in[i] = {addr_packed_i[i*VMEM_ADDRW +: VMEM_ADDRW],
                        rgb565_to_rgb3(wdata_packed_i[i*32 +: 16])};
    // Requests seen while in reset are neither queued nor stalled.
    assign push[i]           = we_packed_i[i] & ~full[i] & ~rst_i;
    assign stall_packed_o[i] = we_packed_i[i] & full[i] & ~rst_i;
    assign pop[i]            = gnt_vld & (gnt_idx == PTR_W'(i));

    vmem_wr_fifo #(
      .DATA_W     (ENT_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (push[i]),
      .din   (ent_in[i]),
      .pop   (pop[i]),
      .dout  (ent_out[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // Grant the first non-empty FIFO at or after the round-robin pointer.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NCORES; k++) begin
      idx = (int'(rr_ptr) + k) % NCORES;
      if (!gnt_vld && !empty[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
  end

  assign rr_next = (gnt_idx == PTR_W'(NCORES - 1)) ? '0 : gnt_idx + 1'b1;
  assign sel_ent = ent_out[gnt_idx];

  // ---- stage p1: registered RAM write port ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= gnt_vld;
      // Address and data hold their last values on idle cycles.
      if (gnt_vld) begin
        rr_ptr   <= rr_next;
        waddr_p1 <= sel_ent[ENT_W-1:3];
        wdata_p1 <= sel_ent[2:0];
      end
    end
  end

  assign mem_we_o    = vld_p1;
  assign mem_waddr_o = waddr_p1;
  assign mem_wdata_o = wdata_p1;
  assign busy_o      = vld_p1 | ~(&empty);

endmodule

// File: tb/tb_vmem_wr_buffer.sv
module tb_vmem_wr_buffer;

  localparam int NC = 3;
  localparam int AW = 16;
  localparam int D  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NC-1:0]    we;
  logic [AW*NC-1:0] addr_p;
  logic [32*NC-1:0] wdata_p;
  logic [NC-1:0]    stall;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [2:0]       mem_wdata;
  logic             busy;

  int total = 0;
  int bad   = 0;

  vmem_wr_buffer #(
    .NCORES     (NC),
    .VMEM_ADDRW (AW),
    .FIFO_DEPTH (D)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .we_packed_i    (we),
    .addr_packed_i  (addr_p),
    .wdata_packed_i (wdata_p),
    .stall_packed_o (stall),
    .mem_we_o       (mem_we),
    .mem_waddr_o    (mem_waddr),
    .mem_wdata_o    (mem_wdata),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per core, a round-robin start index and the
  // expected state of the RAM write port.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [2:0]    c;
  } ent_t;

  ent_t          mq [NC][$];
  int            rr;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [2:0]    m_data;
  logic [AW-1:0] wr_log [$];
  logic [NC-1:0] stall_seen;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  exp;
  } cvec_t;
  cvec_t tbl [7];

  logic          pv [NC];
  logic [AW-1:0] pa [NC];
  logic [31:0]   pd [NC];

  function automatic logic [2:0] ref_conv(input logic [31:0] w);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = w[15:11];
    g = w[10:5];
    b = w[4:0];
    return {r[4], g[5], b[4]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NC; i++) mq[i].delete();
    rr     = 0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic step(output logic [NC-1:0] acc);
    logic [NC-1:0] exp_stall;
    logic          any;
    int            g;
    ent_t          e;
    #1;
    stall_seen |= stall;
    for (int i = 0; i < NC; i++) exp_stall[i] = we[i] && (mq[i].size() >= D);
    chk("stall", stall, exp_stall);
    g = -1;
    for (int k = 0; k < NC; k++) begin
      int idx;
      idx = (rr + k) % NC;
      if (g < 0 && mq[idx].size() > 0) g = idx;
    end
    for (int i = 0; i < NC; i++) acc[i] = we[i] && (mq[i].size() < D);
    if (g >= 0) begin
      e      = mq[g].pop_front();
      m_we   = 1'b1;
      m_addr = e.a;
      m_data = e.c;
      rr     = (g + 1) % NC;
    end else begin
      m_we = 1'b0;
    end
    for (int i = 0; i < NC; i++) begin
      if (acc[i]) begin
        e.a = addr_p[i*AW +: AW];
        e.c = ref_conv(wdata_p[i*32 +: 32]);
        mq[i].push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) wr_log.push_back(mem_waddr);
    any = m_we;
    for (int i = 0; i < NC; i++) if (mq[i].size() > 0) any = 1'b1;
    chk("mem_we", mem_we, m_we);
    chk("mem_waddr", mem_waddr, m_addr);
    chk("mem_wdata", mem_wdata, m_data);
    chk("busy", busy, any);
  endtask

  task automatic idle(input int n);
    logic [NC-1:0] acc;
    we = '0;
    for (int k = 0; k < n; k++) step(acc);
  endtask

  // Assert reset in the middle of a cycle, with all requests high.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    we  = '1;
    #1;
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", stall, '0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    we  = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_waddr", mem_waddr, '0);
    chk("rst_wdata", mem_wdata, '0);
    chk("rst_rel_busy", busy, 1'b0);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [31:0] d);
    we[i]               = 1'b1;
    addr_p[i*AW +: AW]  = a;
    wdata_p[i*32 +: 32] = d;
  endtask

  // Every active core presents stores back to back; address = core<<8 | seq.
  task automatic stream(input logic [NC-1:0] act, input int nreq, input int nwr,
                        input int budget, output int cyc);
    int            seq [NC];
    logic [NC-1:0] acc;
    int            start;
    start = wr_log.size();
    cyc   = 0;
    for (int i = 0; i < NC; i++) seq[i] = 0;
    while ((wr_log.size() - start) < nwr && cyc < budget) begin
      for (int i = 0; i < NC; i++) begin
        we[i]               = act[i] && (seq[i] < nreq);
        addr_p[i*AW +: AW]  = AW'((i << 8) | seq[i]);
        wdata_p[i*32 +: 32] = {16'hA5A5, 16'(seq[i] * 16'h1357 + i * 16'h0F0F)};
      end
      step(acc);
      for (int i = 0; i < NC; i++) if (acc[i]) seq[i]++;
      cyc++;
    end
    we = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] acc;
    int            cyc;
    int            start;
    int            nxt [NC];
    int            cnt [NC];
    int            accepted;
    logic          ok;

    tbl[0] = '{32'h0000F800, 3'b100};
    tbl[1] = '{32'h000007E0, 3'b010};
    tbl[2] = '{32'h0000001F, 3'b001};
    tbl[3] = '{32'h0000FFFF, 3'b111};
    tbl[4] = '{32'h00007BEF, 3'b000};
    tbl[5] = '{32'hFFFF7BEF, 3'b000};
    tbl[6] = '{32'h12348410, 3'b111};

    we         = '0;
    addr_p     = '0;
    wdata_p    = '0;
    stall_seen = '0;
    model_clear();
    do_reset();

    // Single store, fixed latency.
    set_req(0, 16'h0020, 32'h0000F800);
    step(acc);
    chk("t1_accept", acc, 3'b001);
    chk("t1_we_e0", mem_we, 1'b0);
    we = '0;
    step(acc);
    chk("t1_we_e1", mem_we, 1'b1);
    chk("t1_addr", mem_waddr, 16'h0020);
    chk("t1_data", mem_wdata, 3'b100);
    step(acc);
    chk("t1_we_e2", mem_we, 1'b0);
    chk("t1_addr_hold", mem_waddr, 16'h0020);

    // Colour conversion table.
    for (int v = 0; v < 7; v++) begin
      set_req(0, AW'(16'h0100 + v), tbl[v].d);
      step(acc);
      we = '0;
      step(acc);
      chk("conv_we", mem_we, 1'b1);
      chk("conv_data", mem_wdata, tbl[v].exp);
      step(acc);
    end

    // Two cores store on the same edge from an idle state.
    do_reset();
    set_req(0, 16'd1, 32'h0);
    set_req(1, 16'd2, 32'h0);
    step(acc);
    we = '0;
    step(acc);
    chk("t4_first", mem_waddr, 16'd1);
    step(acc);
    chk("t4_second", mem_waddr, 16'd2);
    chk("t4_second_we", mem_we, 1'b1);
    step(acc);
    chk("t4_idle", mem_we, 1'b0);
    // Pointer has moved past core 1, so core 0 wins the next tie.
    set_req(1, 16'd5, 32'h0);
    set_req(0, 16'd6, 32'h0);
    step(acc);
    we = '0;
    step(acc);
    chk("t4_rr_first", mem_waddr, 16'd6);
    step(acc);
    chk("t4_rr_second", mem_waddr, 16'd5);
    idle(2);

    // Two cores streaming 20 stores each.
    do_reset();
    stall_seen = '0;
    start = wr_log.size();
    stream(3'b011, 20, 40, 200, cyc);
    chk("t3_budget", (cyc < 200), 1'b1);
    chk("t3_stall0_seen", stall_seen[0], 1'b1);
    chk("t3_stall1_seen", stall_seen[1], 1'b1);
    for (int i = 0; i < NC; i++) begin
      nxt[i] = 0;
      cnt[i] = 0;
    end
    ok = 1'b1;
    for (int k = start; k < wr_log.size(); k++) begin
      int c;
      int s;
      c = int'(wr_log[k][15:8]);
      s = int'(wr_log[k][7:0]);
      if (c != ((k - start) % 2)) ok = 1'b0;
      if (c < NC) begin
        if (s != nxt[c]) ok = 1'b0;
        nxt[c] = s + 1;
        cnt[c]++;
      end else begin
        ok = 1'b0;
      end
    end
    chk("t3_order_alternate", ok, 1'b1);
    chk("t3_count0", cnt[0], 20);
    chk("t3_count1", cnt[1], 20);
    idle(3);

    // Reset with entries queued.
    do_reset();
    set_req(0, 16'h0050, 32'h0);
    set_req(1, 16'h0051, 32'h0);
    set_req(2, 16'h0052, 32'h0);
    step(acc);
    we = '0;
    step(acc);
    chk("t5_pre_we", mem_we, 1'b1);
    start = wr_log.size();
    do_reset();
    idle(5);
    chk("t5_no_writes", wr_log.size() - start, 0);

    // Three cores streaming continuously.
    do_reset();
    start = wr_log.size();
    stream(3'b111, 200, 30, 200, cyc);
    chk("t6_budget", (cyc < 200), 1'b1);
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    ok = 1'b1;
    for (int k = start; k < start + 30 && k < wr_log.size(); k++) begin
      int c;
      c = int'(wr_log[k][15:8]);
      if (c != ((k - start) % 3)) ok = 1'b0;
      if (c < NC) cnt[c]++;
    end
    chk("t6_pattern", ok, 1'b1);
    chk("t6_count0", cnt[0], 10);
    chk("t6_count1", cnt[1], 10);
    chk("t6_count2", cnt[2], 10);

    // Randomised traffic with held requests.
    do_reset();
    start    = wr_log.size();
    accepted = 0;
    for (int i = 0; i < NC; i++) pv[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NC; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 60) begin
          pv[i] = 1'b1;
          pa[i] = AW'($urandom());
          pd[i] = $urandom();
        end
        we[i]               = pv[i];
        addr_p[i*AW +: AW]  = pa[i];
        wdata_p[i*32 +: 32] = pd[i];
      end
      step(acc);
      for (int i = 0; i < NC; i++) begin
        if (acc[i]) begin
          pv[i] = 1'b0;
          accepted++;
        end
      end
    end
    idle(3 * D + 4);
    chk("rand_write_count", wr_log.size() - start, accepted);
    chk("rand_final_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
